vga_pixel_source: RTL and testbench
===================================

# vga_pixel_source

Upstream pixel stage that feeds the 8-bit grayscale colour input of the VGA output controller. It runs its own 800×525 timing counters in lock-step with the controller, using the same clock and reset. It fetches the decrypted 256×256 image from a dual-bank synchronous RAM with a 3-cycle lookahead and delivers one pixel per clock, with a border level outside the image. Bank swaps requested by the decryption engine are applied only at a frame boundary, so the picture never tears.

## Interface
- IMG_W, 256, image width in pixels (power of two)
- IMG_H, 256, image height in lines
- X0, 192, first image column within the 640-pixel active area
- Y0, 112, first image line within the 480-line active area
- ADDR_W, 17, RAM address width: 1 bank bit + log2(IMG_W·IMG_H)
- BORDER, 8'h00, level driven outside the image and in blanking
- clk_25Mhz  in  1  pixel clock
- rst  in  1  reset, asynchronous, active-high; clock clk_25Mhz
- swap_req  in  1  single-cycle pulse: the inactive bank now holds a complete image
- mem_data  in  8  RAM read data, valid 1 cycle after mem_addr/mem_rd_en
- mem_addr  out  ADDR_W  {bank, row·IMG_W + col}
- mem_rd_en  out  1  read strobe, high only for in-image fetches
- pixel_out  out  8  grayscale level, connected to the controller's colour input
- swap_ack  out  1  single-cycle pulse when a swap takes effect
- frame_start  out  1  single-cycle pulse when the display counter is at (0,0)
- showing  out  1  high once the first image is displayed

## Operation
- Display counter D = (h,v):
  - h runs 0..799 and wraps to 0; v increments on each h wrap and runs 0..524, then wraps to 0.
- Active area: 144 ≤ h < 784 and 35 ≤ v < 515. Active coordinates are ax = h−144 and ay = v−35.
- Lookahead counter A is always D advanced by 3 pixels, with line and frame wrap applied identically. At reset, D=(0,0) and A=(3,0).
- In-image test on A: X0 ≤ ax < X0+IMG_W and Y0 ≤ ay < Y0+IMG_H.
- Fetch pipeline:
  - Stage 1 registers mem_addr, mem_rd_en and the in-image flag.
  - Stage 2 is the RAM latency; the flag is delayed alongside.
  - Stage 3 registers pixel_out: mem_data if the flag is set and state is SHOW, otherwise BORDER.
- Address: col = ax−X0 and row = ay−Y0, so mem_addr = {disp_bank, row·IMG_W+col}. Multiplication is a shift because IMG_W is a power of two. Outside the image, mem_addr holds its last value and mem_rd_en=0.
- State machine:
  - WAIT (reset state): pixel_out=BORDER always; showing=0.
  - WAIT→SHOW at the first A-frame boundary with a pending swap.
  - SHOW: normal display; there is no exit except reset.
- Swap handling:
  - swap_req sets a pending flag.
  - At the A-frame boundary (A wraps to (0,0)), a set pending flag toggles disp_bank, clears pending and pulses swap_ack.
  - Several requests within one frame collapse into one swap.
  - A swap_req coinciding with the boundary cycle is taken at that boundary.
- disp_bank resets to 0; the first swap selects bank 1. The decrypter owns the non-displayed bank.

## Timing
- Reset values:
  - D=(0,0), A=(3,0), state WAIT, pending=0, disp_bank=0.
  - mem_addr=0, mem_rd_en=0, pixel_out=BORDER, swap_ack=0, frame_start=0, showing=0.
- Latency: the fetch for position A(t) = D(t+3) appears on pixel_out at cycle t+3. pixel_out therefore corresponds to the controller's current counter position.
- frame_start is high in the cycle D=(0,0), including the first cycle after reset release.
- swap_ack and the bank/state change are registered together. The first pixel fetched from the new bank is A=(0,0) of that frame.
- showing rises in the same cycle as the WAIT→SHOW swap_ack.
- Reset asserted mid-frame: all state returns to its reset value immediately. The image must be re-requested with swap_req.

## Test plan
- Release reset with no swap_req → frame_start high on cycle 0 and every 420000 cycles; pixel_out=8'h00 and mem_rd_en=0 for a whole frame; showing=0.
- Pulse swap_req at D=(300,200) → swap_ack pulses once, 3 cycles before the next frame_start; showing=1; bank bit of subsequent mem_addr = 1.
- After the swap, with RAM data = low address byte → at D=(336,147) pixel_out=8'h00 (addr 17'h10000); at D=(591,402) pixel_out=8'hFF (addr 17'h1FFFF); at D=(335,147) and (592,402) pixel_out=BORDER.
- Three swap_req pulses within one frame → exactly one swap_ack; disp_bank toggles once.
- swap_req in the same cycle as the A-frame boundary → swap taken at that boundary, not deferred a frame.
- Assert rst while D=(500,300) in SHOW → next cycle all outputs at reset values; state WAIT until a new swap_req.

Source files
------------

// File: rtl/vga_pixel_source.sv
// vga_pixel_source: 800x525 lock-step pixel stage fetching a 256x256 image from a dual-bank RAM with 3-cycle lookahead
//   clk_25Mhz, rst     pixel clock, asynchronous active-high reset
//   swap_req           pulse: inactive bank holds a complete image
//   mem_data           RAM read data, valid one cycle after mem_addr/mem_rd_en
//   mem_addr/mem_rd_en {bank, row*IMG_W+col} fetch address and strobe
//   pixel_out          grayscale level for the controller's current position
//   swap_ack           pulse when a bank swap takes effect
//   frame_start        high while the display counter is at (0,0)
//   showing            high once the first image is displayed
module vga_pixel_source #(
    parameter int          IMG_W  = 256,
    parameter int          IMG_H  = 256,
    parameter int          X0     = 192,
    parameter int          Y0     = 112,
    parameter int          ADDR_W = 17,
    parameter logic [7:0]  BORDER = 8'h00
) (
    input  logic              clk_25Mhz,
    input  logic              rst,
    input  logic              swap_req,
    input  logic [7:0]        mem_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    output logic [7:0]        pixel_out,
    output logic              swap_ack,
    output logic              frame_start,
    output logic              showing
);
    localparam logic [0:0] WAIT = 1'b0;
    localparam logic [0:0] SHOW = 1'b1;
    localparam int CW = $clog2(IMG_W);
    localparam int OW = ADDR_W - 1;
    localparam logic [9:0] XS = 10'(144 + X0);
    localparam logic [9:0] XE = 10'(144 + X0 + IMG_W);
    localparam logic [9:0] YS = 10'(35 + Y0);
    localparam logic [9:0] YE = 10'(35 + Y0 + IMG_H);

    logic [9:0]       h, v, ah, av;
    logic [0:0]       state;
    logic             pending, disp_bank, f1, f2;
    logic             a_wrap, take, in_img, fetch;
    logic [CW-1:0]    col;
    logic [OW-CW-1:0] row;

    // a_wrap marks the last lookahead position of a frame; the bank change
    // registered here is in effect when A reaches (0,0)
    assign a_wrap      = ah == 10'd799 && av == 10'd524;
    assign take        = a_wrap && (pending || swap_req);
    assign in_img      = ah >= XS && ah < XE && av >= YS && av < YE;
    assign fetch       = in_img && state == SHOW;
    assign col         = CW'(ah - XS);
    assign row         = (OW - CW)'(av - YS);
    assign showing     = state == SHOW;
    assign frame_start = !rst && h == 10'd0 && v == 10'd0;

    always_ff @(posedge clk_25Mhz or posedge rst) begin
        if (rst) begin
            h         <= '0;
            v         <= '0;
            ah        <= 10'd3;
            av        <= '0;
            state     <= WAIT;
            pending   <= 1'b0;
            disp_bank <= 1'b0;
            swap_ack  <= 1'b0;
            mem_addr  <= '0;
            mem_rd_en <= 1'b0;
            f1        <= 1'b0;
            f2        <= 1'b0;
            pixel_out <= BORDER;
        end else begin
            h         <= h == 10'd799 ? 10'd0 : h + 10'd1;
            v         <= h == 10'd799 ? (v == 10'd524 ? 10'd0 : v + 10'd1) : v;
            ah        <= ah == 10'd799 ? 10'd0 : ah + 10'd1;
            av        <= ah == 10'd799 ? (av == 10'd524 ? 10'd0 : av + 10'd1) : av;
            pending   <= a_wrap ? 1'b0 : pending || swap_req;
            swap_ack  <= take;
            disp_bank <= take ? !disp_bank : disp_bank;
            state     <= take ? SHOW : state;
            mem_addr  <= fetch ? {disp_bank, row, col} : mem_addr;
            mem_rd_en <= fetch;
            f1        <= fetch;
            f2        <= f1;
            pixel_out <= (f2 && state == SHOW) ? mem_data : BORDER;
        end
    end
endmodule

// File: tb/tb_vga_pixel_source.sv
// tb_vga_pixel_source: directed checks of frame timing, swap handling, image fetch and reset
`timescale 1ns/1ps
module tb_vga_pixel_source;
    logic        clk_25Mhz = 1'b0;
    logic        rst = 1'b1;
    logic        swap_req = 1'b0;
    logic [7:0]  mem_data = 8'h00;
    logic [16:0] mem_addr;
    logic        mem_rd_en;
    logic [7:0]  pixel_out;
    logic        swap_ack;
    logic        frame_start;
    logic        showing;
    int          tests = 0;
    int          fails = 0;
    int          th = 0;
    int          tv = 0;

    vga_pixel_source dut (
        .clk_25Mhz  (clk_25Mhz),
        .rst        (rst),
        .swap_req   (swap_req),
        .mem_data   (mem_data),
        .mem_addr   (mem_addr),
        .mem_rd_en  (mem_rd_en),
        .pixel_out  (pixel_out),
        .swap_ack   (swap_ack),
        .frame_start(frame_start),
        .showing    (showing)
    );

    always #20 clk_25Mhz = ~clk_25Mhz;

    // synchronous RAM returning the low address byte
    always @(posedge clk_25Mhz) if (mem_rd_en) mem_data <= mem_addr[7:0];

    // reference display position
    always @(posedge clk_25Mhz or posedge rst) begin
        if (rst) begin
            th <= 0;
            tv <= 0;
        end else begin
            th <= th == 799 ? 0 : th + 1;
            if (th == 799) tv <= tv == 524 ? 0 : tv + 1;
        end
    end

    task automatic wait_d(input int h, input int v);
        int n = 0;
        while (!(th == h && tv == v) && n < 500000) begin
            @(negedge clk_25Mhz);
            n++;
        end
        if (n >= 500000) begin
            fails++;
            $display("FAIL wait_d(%0d,%0d): timeout, position %0d,%0d", h, v, th, tv);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        tests++;
        if ({mem_addr, mem_rd_en, pixel_out, swap_ack, frame_start, showing} !== 30'd0) begin
            fails++;
            $display("FAIL %s: addr=%h rd=%b pix=%h ack=%b fs=%b show=%b, required all zero",
                     tag, mem_addr, mem_rd_en, pixel_out, swap_ack, frame_start, showing);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk_25Mhz);
        check_reset_outputs("reset_values");
        rst = 1'b0;
        #1;
        tests++;
        if (frame_start !== 1'b1) begin
            fails++;
            $display("FAIL frame_start_cycle0: got %b, required 1", frame_start);
        end
    endtask

    // Frame 1: idle in WAIT, three swap requests collapse into one swap at the boundary
    task automatic test_idle_frame();
        int fs_extra = 0, acks = 0, ack_n = -1, bad_pix = 0, bad_show = 0;
        for (int n = 0; n < 420000; n++) begin
            if (n > 0 && frame_start) fs_extra++;
            if (swap_ack) begin acks++; ack_n = n; end
            if (pixel_out !== 8'h00 || mem_rd_en !== 1'b0) bad_pix++;
            if (showing !== (n >= 419997)) bad_show++;
            swap_req = (n == 200*800 + 300) || (n == 200*800 + 310) || (n == 400*800 + 100);
            @(negedge clk_25Mhz);
        end
        swap_req = 1'b0;
        tests++;
        if (fs_extra !== 0) begin fails++; $display("FAIL frame_start_extra: %0d extra pulses, required 0", fs_extra); end
        tests++;
        if (acks !== 1) begin fails++; $display("FAIL swap_ack_count: %0d, required 1", acks); end
        tests++;
        if (ack_n !== 419997) begin fails++; $display("FAIL swap_ack_cycle: %0d, required 419997", ack_n); end
        tests++;
        if (bad_pix !== 0) begin fails++; $display("FAIL idle_border: %0d cycles with pixel/rd_en active, required 0", bad_pix); end
        tests++;
        if (bad_show !== 0) begin fails++; $display("FAIL showing_rise: %0d wrong cycles, required 0", bad_show); end
        tests++;
        if (frame_start !== 1'b1 || th !== 0 || tv !== 0) begin
            fails++;
            $display("FAIL frame_start_420000: got %b at %0d,%0d, required 1 at 0,0", frame_start, th, tv);
        end
    endtask

    task automatic chk_addr(input string tag, input int h, input int v, input logic rd, input logic [16:0] a);
        wait_d(h, v);
        tests++;
        if (mem_rd_en !== rd || (rd && mem_addr !== a) || (!rd && a !== 17'h0 && mem_addr !== a)) begin
            fails++;
            $display("FAIL %s: rd=%b addr=%h, required rd=%b addr=%h", tag, mem_rd_en, mem_addr, rd, a);
        end
    endtask

    task automatic chk_pix(input string tag, input int h, input int v, input logic [7:0] p);
        wait_d(h, v);
        tests++;
        if (pixel_out !== p) begin
            fails++;
            $display("FAIL %s: pixel=%h, required %h", tag, pixel_out, p);
        end
    endtask

    // Frame 2: image from bank 1
    task automatic test_image();
        chk_addr("rd_before_image", 333, 147, 1'b0, 17'h0);
        chk_addr("addr_first", 334, 147, 1'b1, 17'h10000);
        chk_pix("pix_left_border", 335, 147, 8'h00);
        chk_pix("pix_first", 336, 147, 8'h00);
        chk_pix("pix_second", 337, 147, 8'h01);
        chk_pix("pix_mid", 400, 200, 8'h40);
        chk_addr("addr_mid", 403, 200, 1'b1, 17'h13545);
        chk_addr("addr_last", 589, 402, 1'b1, 17'h1FFFF);
        chk_addr("addr_hold", 590, 402, 1'b0, 17'h1FFFF);
        chk_pix("pix_penult", 590, 402, 8'hFE);
        chk_pix("pix_last", 591, 402, 8'hFF);
        chk_pix("pix_right_border", 592, 402, 8'h00);
    endtask

    // swap_req on the lookahead boundary cycle is taken immediately
    task automatic test_boundary_swap();
        wait_d(796, 524);
        swap_req = 1'b1;
        @(negedge clk_25Mhz);
        swap_req = 1'b0;
        tests++;
        if (swap_ack !== 1'b1) begin fails++; $display("FAIL boundary_ack: got %b, required 1", swap_ack); end
        @(negedge clk_25Mhz);
        tests++;
        if (swap_ack !== 1'b0) begin fails++; $display("FAIL ack_single: got %b, required 0", swap_ack); end
        chk_addr("bank0_addr", 334, 147, 1'b1, 17'h00000);
        chk_pix("bank0_pix", 340, 147, 8'h04);
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        wait_d(500, 300);
        rst = 1'b1;
        #1;
        check_reset_outputs("reset_async");
        @(negedge clk_25Mhz);
        check_reset_outputs("reset_held");
        rst = 1'b0;
        #1;
        tests++;
        if (frame_start !== 1'b1) begin fails++; $display("FAIL frame_start_after_reset: got %b, required 1", frame_start); end
        for (int n = 0; n < 140000; n++) begin
            @(negedge clk_25Mhz);
            if (pixel_out !== 8'h00 || mem_rd_en !== 1'b0 || showing !== 1'b0 || swap_ack !== 1'b0) bad++;
        end
        tests++;
        if (bad !== 0) begin fails++; $display("FAIL wait_after_reset: %0d active cycles, required 0", bad); end
    endtask

    initial begin
        test_reset();
        test_idle_frame();
        test_image();
        test_boundary_swap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
